// File: rtl/sms_card_ring_trigger_if.sv
// Ring trigger card bus: advance, inhibit, direction and preset lines
// in; one-hot position, inverter-drive position and wrap carry out.
interface sms_card_ring_trigger_if #(
    parameter int POSITIONS = 4
);
    logic                 adv_n;
    logic                 inh_n;
    logic                 dir;
    logic                 set_n;
    logic [POSITIONS-1:0] pos;
    logic [POSITIONS-1:0] pos_n;
    logic                 carry;

    modport master (
        output adv_n, inh_n, dir, set_n,
        input  pos, pos_n, carry
    );

    modport slave (
        input  adv_n, inh_n, dir, set_n,
        output pos, pos_n, carry
    );
endinterface

// File: rtl/sms_card_ring_trigger.sv
// One-hot ring counter stepped by falling edges on adv_n.
// SMS_RING_OPEN_COLLECTOR_EN: pos_n drives 0 when active, z otherwise.
module sms_card_ring_trigger #(
    parameter int POSITIONS = 4,
    parameter int RESET_POS = 0
) (
    input logic                    clk,
    input logic                    rst,
    sms_card_ring_trigger_if.slave ring
);
    localparam int P = POSITIONS;
    localparam logic [P-1:0] POS0 = P'(1);
    localparam logic [P-1:0] POSR = P'(1) << RESET_POS;

    // Card inputs have pull-ups: only a clean 0 is low.
    function automatic logic pu(input logic v);
        return (v === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    logic         adv_r, inh_r, dir_r, set_r;
    logic         adv_prev_q;
    logic         adv_fall;
    logic         onehot;
    logic [P-1:0] pos_q, pos_d;
    logic         carry_q, carry_d;

    assign adv_r = pu(ring.adv_n);
    assign inh_r = pu(ring.inh_n);
    assign dir_r = pu(ring.dir);
    assign set_r = pu(ring.set_n);

    assign adv_fall = adv_prev_q & ~adv_r;
    assign onehot   = (pos_q != '0) && ((pos_q & (pos_q - P'(1))) == '0);

    always_comb begin
        pos_d   = pos_q;
        carry_d = 1'b0;
        if (!set_r) begin
            pos_d = POS0;
        end else if (adv_fall) begin
            // Corrupted ring recovers to position 0 on the next edge.
            if (!onehot) begin
                pos_d = POS0;
            end else if (!inh_r) begin
                pos_d = pos_q;
            end else if (dir_r) begin
                pos_d   = {pos_q[P-2:0], pos_q[P-1]};
                carry_d = pos_q[P-1];
            end else begin
                pos_d   = {pos_q[0], pos_q[P-1:1]};
                carry_d = pos_q[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q      <= POSR;
            carry_q    <= 1'b0;
            adv_prev_q <= 1'b1;
        end else begin
            pos_q      <= pos_d;
            carry_q    <= carry_d;
            adv_prev_q <= adv_r;
        end
    end

    assign ring.pos   = pos_q;
    assign ring.carry = carry_q;

`ifdef SMS_RING_OPEN_COLLECTOR_EN
    for (genvar i = 0; i < P; i++) begin : g_oc
        assign ring.pos_n[i] = pos_q[i] ? 1'b0 : 1'bz;
    end
`else
    assign ring.pos_n = ~pos_q;
`endif
endmodule

// File: doc/sms_card_ring_trigger.md
Name: sms_card_ring_trigger

Overview:
- Synchronous ring-counter trigger card: a one-hot ring of POSITIONS stages, advanced by falling edges on a gated advance line.
- Sits directly upstream of the SDTRL inverter cards. The active-low position outputs drive inverter inputs, which decode ring timing and sequencing.
- Inputs follow card pull-up semantics: z or x reads as logic 1 (inactive).

Parameters:
- POSITIONS, 4: number of ring stages; legal range 2..16.
- RESET_POS, 0: position that is active after reset; legal range 0..POSITIONS-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- adv_n  input  1  advance line, active-low; z reads as 1.
- inh_n  input  1  advance inhibit, active-low; z reads as 1.
- dir  input  1  1 or z = forward (i to i+1); 0 = reverse (i to i-1).
- set_n  input  1  synchronous preset to position 0, active-low; z reads as 1.
- pos  output  POSITIONS  one-hot position, active-high.
- pos_n  output  POSITIONS  complement of pos; feeds inverter cards.
- carry  output  1  one-cycle pulse on ring wrap.

Behaviour:
- Input resolution: every input passes through a pull-up function. Only a clean 0 is low; 1, z and x all read as 1.
- Reset: while rst=1, asynchronously:
  - pos = one-hot RESET_POS; pos_n = ~pos;
  - carry = 0;
  - adv_prev = 1.
  - Reset asserted mid-operation wins immediately, including over a pending edge.
- Edge detect:
  - adv_prev is registered every cycle from resolved adv_n.
  - adv_fall = (adv_prev==1) && (adv_n resolved==0).
  - A line held low advances exactly once. Glitches shorter than one clk are not guaranteed to be seen.
- Next-state priority, evaluated each rising edge:
  1. set_n low: pos = one-hot 0, carry = 0. Any coincident adv_fall is consumed and discarded.
  2. adv_fall with inh_n low: edge consumed; pos holds; carry = 0. Releasing inh_n does not replay the edge.
  3. adv_fall, forward: pos rotates up by one. If the old position was POSITIONS-1, the new position is 0 and carry = 1.
  4. adv_fall, reverse: pos rotates down by one. If the old position was 0, the new position is POSITIONS-1 and carry = 1.
  5. Otherwise: pos holds; carry = 0.
- Latency: pos and carry change on the first rising edge at which adv_n is sampled low after being sampled high. That is one clk after the falling level is present at the flop input.
- carry is registered and lasts exactly one cycle. Back-to-back wraps, e.g. POSITIONS=2 with edges on consecutive cycles, produce consecutive carry pulses.
- One-hot integrity:
  - If pos is ever not one-hot (X-injection, SEU), the next adv_fall or set_n forces one-hot 0.
  - pos otherwise holds its value.
  - This is a recovery path only; no error flag.
- dir is sampled in the same cycle as adv_fall. Changing dir without an edge has no effect.
- pos_n is combinationally ~pos, with no extra register stage (subject to the optional feature).

Optional Feature:
- Macro: SMS_RING_OPEN_COLLECTOR_EN.
- Defined: each pos_n bit drives 0 when its position is active and 1'bz otherwise. This models the open-collector output option so several cards can dot-OR onto one line; downstream pull-up resolves it to 1.
- Undefined: pos_n bits drive a hard 0/1. pos and carry are always driven in both builds.

Test Plan:
- Reset: POSITIONS=4, RESET_POS=2; pulse rst mid-cycle -> pos=0100, pos_n=1011, carry=0 immediately, with no clk edge needed.
- Forward wrap: from pos=1000, one adv_n high->low with dir=1 -> next cycle pos=0001, carry=1 for exactly one cycle. Holding adv_n low 5 more cycles -> no further change.
- Reverse wrap with z inputs: dir=0, inh_n=z, set_n=z, pos=0001, one falling edge -> pos=1000, carry=1. Then dir=z plus one edge -> pos=0001, carry=1.
- Inhibit consumes edge: inh_n=0 during a falling edge from pos=0010 -> pos stays 0010. Release inh_n with adv_n still low -> pos stays 0010. Next falling edge -> pos=0100, carry=0.
- Preset priority: set_n=0 coincident with a falling edge at pos=0100 -> pos=0001, carry=0. Raising adv_n then lowering it once -> pos=0010.
- Open collector (macro defined): pos=0010 -> pos_n=zz0z. Without the macro -> pos_n=1101.
